// File: rtl/qos_pkg.sv
// Shared definitions for the QoS output side: word/lane sizing, egress FSM
// state encodings and small lane helpers.
package qos_pkg;

    localparam int DATA_W  = 12;
    localparam int NLANES  = 4;
    localparam int LANE_W  = 2;
    localparam int BURST_W = 4;     // wide enough for weights up to 15

    typedef logic [LANE_W-1:0] lane_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_FLUSH = 2'd2
    } drain_state_e;

    // One-hot pop vector for a single lane.
    function automatic logic [NLANES-1:0] lane_onehot(input lane_t lane);
        return NLANES'(1) << lane;
    endfunction

endpackage

// File: rtl/egress_obuf.sv
// Small synchronous FIFO used as the egress output buffer. Read data is
// presented combinationally from the head entry and forced to zero while the
// buffer is empty, so the egress word is clean after reset.
module egress_obuf #(
    parameter  int WIDTH = 14,
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             rd_ok;
    logic             wr_ok;

    assign empty   = (count == '0);
    assign rd_ok   = rd_en && !empty;
    assign wr_ok   = wr_en && ((count != CNT_W'(DEPTH)) || rd_ok);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two).
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // Storage array write.
    // NOTE: the data array has no reset; only pointers and count need a known
    // value, and rd_data is masked while empty so stale entries never leak.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous write and read keep count.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (rd_ok) begin
                rd_ptr <= bump(rd_ptr);
            end
            count <= count + CNT_W'(wr_ok) - CNT_W'(rd_ok);
        end
    end

endmodule

// File: rtl/egress_drain.sv
// Drains the four QoS output FIFOs with weighted round-robin service and
// serialises the words onto one valid/ready egress stream tagged with the
// source lane. A pop issued in cycle t returns data in t+1, which is written
// into the output buffer at the end of t+1; the buffer absorbs that latency
// and any egress backpressure.
module egress_drain #(
    parameter int DATA_W     = qos_pkg::DATA_W,
    parameter int OBUF_DEPTH = 2,
    parameter int WEIGHT0    = 1,
    parameter int WEIGHT1    = 1,
    parameter int WEIGHT2    = 1,
    parameter int WEIGHT3    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [3:0]        lane_empty,
    input  logic [DATA_W-1:0] lane_data0,
    input  logic [DATA_W-1:0] lane_data1,
    input  logic [DATA_W-1:0] lane_data2,
    input  logic [DATA_W-1:0] lane_data3,
    output logic [3:0]        lane_pop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_lane,
    output logic              drain_idle
);

    import qos_pkg::*;

    localparam int CNT_W   = $clog2(OBUF_DEPTH + 1);
    localparam int OCC_W   = CNT_W + 1;
    localparam int ENTRY_W = LANE_W + DATA_W;

    drain_state_e       state;
    lane_t              rr_ptr;
    logic [BURST_W-1:0] burst_cnt;
    logic               inflight;
    lane_t              inflight_lane;

    lane_t              sel_lane;
    lane_t              cand;
    logic               keep;
    logic               found;
    logic               has_work;
    logic               rd_fire;
    logic [OCC_W-1:0]   occ_after;
    logic               credit_ok;
    logic               pop_fire;

    logic [DATA_W-1:0]  inflight_data;
    logic [ENTRY_W-1:0] buf_rd_data;
    logic [CNT_W-1:0]   buf_count;
    logic               buf_empty;

    function automatic logic [BURST_W-1:0] weight_of(input lane_t lane);
        logic [BURST_W-1:0] w;
        case (lane)
            2'd0:    w = BURST_W'(WEIGHT0);
            2'd1:    w = BURST_W'(WEIGHT1);
            2'd2:    w = BURST_W'(WEIGHT2);
            default: w = BURST_W'(WEIGHT3);
        endcase
        return w;
    endfunction

    assign has_work  = |(~lane_empty);
    assign out_valid = !buf_empty;
    assign rd_fire   = out_valid && out_ready;

    // Pop credit: occupancy the buffer will hold after this cycle, counting the
    // word already in flight and the word leaving now, must leave room for one
    // more. Crediting the outgoing word is what sustains 1 word/cycle at depth 2.
    assign occ_after = OCC_W'(buf_count) + OCC_W'(inflight) - OCC_W'(rd_fire);
    assign credit_ok = occ_after < OCC_W'(OBUF_DEPTH);
    assign pop_fire  = (state == ST_SERVE) && en && has_work && credit_ok;

    // WRR lane choice: stay on the current lane while it has words and weight
    // left, otherwise take the next non-empty lane after it (wrapping to itself).
    // NOTE: every always_comb output gets a default first so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        keep     = !lane_empty[rr_ptr] && (burst_cnt < weight_of(rr_ptr));
        sel_lane = rr_ptr;
        cand     = rr_ptr;
        found    = 1'b0;
        if (!keep) begin
            for (int k = 1; k <= NLANES; k++) begin
                cand = rr_ptr + lane_t'(k);
                if (!found && !lane_empty[cand]) begin
                    sel_lane = cand;
                    found    = 1'b1;
                end
            end
        end
        lane_pop = pop_fire ? lane_onehot(sel_lane) : '0;
    end

    // Select the FIFO output of the lane popped in the previous cycle.
    always_comb begin
        case (inflight_lane)
            2'd0:    inflight_data = lane_data0;
            2'd1:    inflight_data = lane_data1;
            2'd2:    inflight_data = lane_data2;
            default: inflight_data = lane_data3;
        endcase
    end

    // Track the word in flight and the WRR pointer / burst count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight      <= 1'b0;
            inflight_lane <= '0;
            rr_ptr        <= '0;
            burst_cnt     <= '0;
        end else begin
            inflight <= pop_fire;
            if (pop_fire) begin
                inflight_lane <= sel_lane;
                if (keep) begin
                    burst_cnt <= burst_cnt + 1'b1;
                end else begin
                    rr_ptr    <= sel_lane;
                    burst_cnt <= BURST_W'(1);
                end
            end
        end
    end

    // Drain FSM with registered idle flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            drain_idle <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en && has_work) begin
                        state      <= ST_SERVE;
                        drain_idle <= 1'b0;
                    end
                end
                ST_SERVE: begin
                    if (!en) begin
                        state <= ST_FLUSH;
                    end else if (!has_work && !inflight && buf_empty) begin
                        state      <= ST_IDLE;
                        drain_idle <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (en) begin
                        state <= ST_SERVE;
                    end else if (!inflight && buf_empty) begin
                        state      <= ST_IDLE;
                        drain_idle <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    drain_idle <= 1'b1;
                end
            endcase
        end
    end

    egress_obuf #(
        .WIDTH (ENTRY_W),
        .DEPTH (OBUF_DEPTH)
    ) u_obuf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (inflight),
        .wr_data ({inflight_lane, inflight_data}),
        .rd_en   (out_ready),
        .rd_data (buf_rd_data),
        .count   (buf_count),
        .empty   (buf_empty)
    );

    assign {out_lane, out_data} = buf_rd_data;

endmodule
